// File: rtl/sdram_wburst_feeder_if.sv
// FIFO-read and SDRAM write-burst signals of the burst feeder.
// The feeder takes the master view; the FIFO/controller side takes the slave view.
interface sdram_wburst_feeder_if #(
    parameter int unsigned ADDR_W = 22
);
    logic              enable;
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [15:0]       fifo_rd_data;
    logic              wr_req;
    logic              wr_ack;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_data_en;
    logic [15:0]       wr_data;
    logic [1:0]        wr_dqm;
    logic              wr_done;
    logic [15:0]       masked_cnt;

    modport master (
        input  enable, fifo_empty, fifo_rd_data, wr_ack,
        output fifo_rd_en, wr_req, wr_addr, wr_data_en, wr_data, wr_dqm, wr_done, masked_cnt
    );

    modport slave (
        output enable, fifo_empty, fifo_rd_data, wr_ack,
        input  fifo_rd_en, wr_req, wr_addr, wr_data_en, wr_data, wr_dqm, wr_done, masked_cnt
    );
endinterface

// File: rtl/sdram_wburst_feeder.sv
// Drains the write FIFO into fixed-length SDRAM write bursts with linear, wrapping addresses;
// beats missing because the FIFO ran dry are masked rather than shortening the burst.
module sdram_wburst_feeder #(
    parameter int unsigned ADDR_W    = 22,
    parameter int unsigned BURST_LEN = 8,
    parameter int unsigned ADDR_BASE = 0,
    parameter int unsigned ADDR_END  = 4194304
) (
    input logic                   clk,
    input logic                   rst_n,
    sdram_wburst_feeder_if.master bus
);
    localparam int unsigned CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(ADDR_BASE);
    localparam logic [ADDR_W:0]   END_X     = (ADDR_W + 1)'(ADDR_END);
    localparam logic [ADDR_W:0]   LEN_X     = (ADDR_W + 1)'(BURST_LEN);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {StIdle, StReq, StData, StFlush, StDone} state_e;

    state_e           state;
    logic [CNT_W-1:0] beat_cnt;
    logic             pop_d;
    logic             hit_d;
    logic [ADDR_W:0]  next_sum;

    // Pop is combinational so a word lands on fifo_rd_data exactly one cycle later.
    assign bus.fifo_rd_en = (state == StData) && !bus.fifo_empty;
    assign next_sum       = {1'b0, bus.wr_addr} + LEN_X;

    // Beat stage: registered RAM output of the FIFO is forwarded, or masked when nothing was popped.
    assign bus.wr_data_en = pop_d;
    assign bus.wr_data    = hit_d ? bus.fifo_rd_data : 16'h0000;
    assign bus.wr_dqm     = hit_d ? 2'b00 : 2'b11;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= StIdle;
            beat_cnt       <= '0;
            pop_d          <= 1'b0;
            hit_d          <= 1'b0;
            bus.wr_req     <= 1'b0;
            bus.wr_addr    <= BASE;
            bus.wr_done    <= 1'b0;
            bus.masked_cnt <= 16'h0000;
        end else begin
            pop_d       <= (state == StData);
            hit_d       <= bus.fifo_rd_en;
            bus.wr_done <= 1'b0;

            if (pop_d && !hit_d && (bus.masked_cnt != 16'hFFFF)) begin
                bus.masked_cnt <= bus.masked_cnt + 16'd1;
            end

            unique case (state)
                StIdle: begin
                    if (bus.enable && !bus.fifo_empty) begin
                        state      <= StReq;
                        bus.wr_req <= 1'b1;
                    end
                end
                StReq: begin
                    if (bus.wr_ack) begin
                        state      <= StData;
                        bus.wr_req <= 1'b0;
                        beat_cnt   <= '0;
                    end
                end
                StData: begin
                    beat_cnt <= beat_cnt + CNT_W'(1);
                    if (beat_cnt == LAST_BEAT) begin
                        state <= StFlush;
                    end
                end
                StFlush: begin
                    state       <= StDone;
                    bus.wr_done <= 1'b1;
                end
                StDone: begin
                    state       <= StIdle;
                    // Sum is one bit wider so an end at 2**ADDR_W still wraps.
                    bus.wr_addr <= (next_sum >= END_X) ? BASE : next_sum[ADDR_W-1:0];
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_wburst_feeder.sv
// Randomized bench for sdram_wburst_feeder: a queue-based FIFO and burst model feed a scoreboard
// that an independent monitor drains whenever the DUT presents a request, beat or done pulse.
module tb_sdram_wburst_feeder;
    localparam int unsigned ADDR_W    = 22;
    localparam int unsigned BURST_LEN = 8;
    localparam int unsigned ADDR_BASE = 0;
    localparam int unsigned ADDR_END  = 32;

    logic clk = 1'b0;
    logic rst_n;

    sdram_wburst_feeder_if #(.ADDR_W(ADDR_W)) bus ();

    sdram_wburst_feeder #(
        .ADDR_W   (ADDR_W),
        .BURST_LEN(BURST_LEN),
        .ADDR_BASE(ADDR_BASE),
        .ADDR_END (ADDR_END)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] fifo_q[$];   // contents of the modelled FIFO
    logic [15:0] model_q[$];  // reference copy used to predict bursts
    logic [17:0] beat_q[$];   // expected {dqm, data} per beat
    int          addr_q[$];   // expected burst start addresses
    int          done_q[$];   // expected masked_cnt at each wr_done
    int          exp_addr   = ADDR_BASE;
    int          exp_masked = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: event occurred, expected none", name);
    endtask

    // FIFO with registered read data; empty flag follows the queue one edge later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q.delete();
            bus.fifo_empty   <= 1'b1;
            bus.fifo_rd_data <= 16'h0000;
        end else begin
            if (bus.fifo_rd_en) begin
                if (fifo_q.size() == 0) fail_now("fifo_underflow");
                else bus.fifo_rd_data <= fifo_q.pop_front();
            end
            bus.fifo_empty <= (fifo_q.size() == 0);
        end
    end

    // Monitor / scoreboard
    int   mon_beats = 0;
    logic prev_req  = 1'b0;
    int   cur_addr  = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_beats = 0;
            prev_req  = 1'b0;
        end else begin
            if (bus.fifo_empty) chk("no_pop_when_empty", 32'(bus.fifo_rd_en), 32'd0);
            if (bus.wr_req && !prev_req) begin
                if (addr_q.size() == 0) fail_now("unexpected_wr_req");
                else begin
                    cur_addr = addr_q.pop_front();
                    chk("wr_addr", 32'(bus.wr_addr), 32'(cur_addr));
                end
            end
            prev_req = bus.wr_req;
            if (bus.wr_data_en) begin
                mon_beats++;
                chk("beat_addr_stable", 32'(bus.wr_addr), 32'(cur_addr));
                if (beat_q.size() == 0) fail_now("unexpected_beat");
                else chk("beat_dqm_data", 32'({bus.wr_dqm, bus.wr_data}), 32'(beat_q.pop_front()));
            end
            if (bus.wr_done) begin
                chk("beats_per_burst", 32'(mon_beats), 32'(BURST_LEN));
                mon_beats = 0;
                if (done_q.size() == 0) fail_now("unexpected_wr_done");
                else chk("masked_cnt", 32'(bus.masked_cnt), 32'(done_q.pop_front()));
            end
        end
    end

    // Load the FIFO and predict the whole next burst from the queue contents.
    task automatic queue_burst(input int n, input bit fixed, output int a);
        logic [15:0] w;
        int          nb;
        if (n == 0 && model_q.size() == 0) n = 1;
        for (int i = 0; i < n; i++) begin
            w = fixed ? 16'((i + 1) * 'h1111) : 16'($urandom);
            fifo_q.push_back(w);
            model_q.push_back(w);
        end
        nb = (model_q.size() < BURST_LEN) ? model_q.size() : BURST_LEN;
        for (int k = 0; k < BURST_LEN; k++) begin
            if (k < nb) beat_q.push_back({2'b00, model_q.pop_front()});
            else beat_q.push_back({2'b11, 16'h0000});
        end
        exp_masked += BURST_LEN - nb;
        if (exp_masked > 'hFFFF) exp_masked = 'hFFFF;
        done_q.push_back(exp_masked);
        a = exp_addr;
        addr_q.push_back(exp_addr);
        exp_addr = (exp_addr + BURST_LEN >= ADDR_END) ? ADDR_BASE : exp_addr + BURST_LEN;
    endtask

    task automatic wait_req(output bit ok);
        int cyc = 0;
        while (!bus.wr_req && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        ok = bus.wr_req;
        if (!ok) fail_now("wr_req_timeout");
    endtask

    task automatic pulse_ack();
        bus.wr_ack = 1'b1;
        @(posedge clk); #1;
        bus.wr_ack = 1'b0;
    endtask

    task automatic run_burst(input int n, input bit fixed, input int ack_dly);
        int a;
        int cyc;
        bit ok;
        queue_burst(n, fixed, a);
        bus.enable = 1'b1;
        wait_req(ok);
        bus.enable = 1'b0;
        if (!ok) return;
        for (int i = 0; i < ack_dly; i++) begin
            @(posedge clk); #1;
            if (ack_dly >= 10) begin
                chk("req_held", 32'(bus.wr_req), 32'd1);
                chk("addr_held", 32'(bus.wr_addr), 32'(a));
                chk("no_pop_in_req", 32'(bus.fifo_rd_en), 32'd0);
            end
        end
        pulse_ack();
        cyc = 0;
        while (!bus.wr_done && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!bus.wr_done) begin
            fail_now("wr_done_timeout");
            return;
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("no_req_while_disabled", 32'(bus.wr_req), 32'd0);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_wr_req"}, 32'(bus.wr_req), 32'd0);
        chk({tag, "_fifo_rd_en"}, 32'(bus.fifo_rd_en), 32'd0);
        chk({tag, "_wr_addr"}, 32'(bus.wr_addr), 32'(ADDR_BASE));
        chk({tag, "_wr_data_en"}, 32'(bus.wr_data_en), 32'd0);
        chk({tag, "_wr_data"}, 32'(bus.wr_data), 32'd0);
        chk({tag, "_wr_dqm"}, 32'(bus.wr_dqm), 32'd3);
        chk({tag, "_wr_done"}, 32'(bus.wr_done), 32'd0);
        chk({tag, "_masked_cnt"}, 32'(bus.masked_cnt), 32'd0);
    endtask

    initial begin
        int  a;
        int  cyc;
        bit  ok;
        rst_n      = 1'b0;
        bus.enable = 1'b0;
        bus.wr_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Stray acknowledge while idle must not start anything.
        pulse_ack();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stray_ack_no_req", 32'(bus.wr_req), 32'd0);
        end

        run_burst(8, 1'b1, 3);    // full burst 0x1111..0x8888
        run_burst(3, 1'b0, 1);    // underrun: five masked beats
        run_burst(8, 1'b0, 20);   // acknowledge withheld
        run_burst(12, 1'b0, 0);   // leftovers stay while enable is low
        for (int i = 0; i < 12; i++) begin
            run_burst(int'($urandom_range(0, 12)), 1'b0, int'($urandom_range(0, 4)));
        end

        // Asynchronous reset in the middle of a data phase.
        queue_burst(8, 1'b0, a);
        bus.enable = 1'b1;
        wait_req(ok);
        bus.enable = 1'b0;
        if (ok) begin
            pulse_ack();
            cyc = 0;
            while (!bus.wr_data_en && cyc < 20) begin
                @(posedge clk); #1;
                cyc++;
            end
            if (!bus.wr_data_en) fail_now("data_phase_timeout");
        end
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_rst");
        beat_q.delete();
        addr_q.delete();
        done_q.delete();
        model_q.delete();
        exp_addr   = ADDR_BASE;
        exp_masked = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_burst(5, 1'b0, 2);
        run_burst(0, 1'b0, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
